serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-009 The block SHALL have port diff, output, WIDTH bits: registered result, (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit: registered borrow-out, 1 when a < b (unsigned).

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL be accepted with these effects:
- a and b captured into internal shift registers
- borrow flop cleared to 0
- bit counter cleared to 0
- next state RUN
REQ-013 In RUN, start SHALL be ignored, and a and b SHALL have no effect on the operation in progress.
REQ-014 Each RUN cycle SHALL process one bit, LSB first, with ai and bi the current LSBs of the operand shift registers and br the borrow flop:
- d = ai XOR bi XOR br
- br_next = (NOT ai AND bi) OR (NOT (ai XOR bi) AND br)
REQ-015 Each RUN cycle SHALL shift the operand registers right by one and shift d into the MSB of an internal result shift register.
REQ-016 After the WIDTH-th RUN cycle, the FSM SHALL enter DONE and, on that same edge, load diff from the result register and bout from br_next.
REQ-017 Latency SHALL be fixed: start accepted at edge N, done high during the cycle after edge N+WIDTH, for exactly one cycle.
REQ-018 From DONE without start, the FSM SHALL return to IDLE on the next edge.
REQ-019 busy SHALL be high exactly while the state is RUN.
REQ-020 done SHALL be high exactly while the state is DONE.
REQ-021 diff and bout SHALL change only on the DONE-entry edge or on reset, and SHALL hold their value through IDLE and RUN.
REQ-022 start accepted in DONE SHALL begin a new operation with no idle cycle; done still pulses for that cycle only.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.
REQ-024 Boundary values SHALL be computed correctly: a=b gives diff=0, bout=0; a=0, b=2^WIDTH-1 gives diff=1, bout=1.

Reset
REQ-025 While rst_n=0, the block SHALL immediately, without waiting for a clock edge:
- force state to IDLE
- clear busy, done, diff, bout, the borrow flop, the counter and all shift registers
REQ-026 Assertion of rst_n mid-operation SHALL abort the operation; no done pulse and no diff/bout update SHALL follow.
REQ-027 After rst_n is deasserted, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 Basic subtraction: start with a=0x5A, b=0x3C -> busy high 8 cycles, then done for 1 cycle with diff=0x1E, bout=0.
REQ-029 Underflow and equal operands, each as a separate operation:
- a=0x00, b=0x01 -> diff=0xFF, bout=1
- a=0xFF, b=0xFF -> diff=0x00, bout=0
REQ-030 Start while busy: pulse start with a=0x10, b=0x01 three cycles into an a=0x80, b=0x01 operation -> single done pulse with diff=0x7F, bout=0; no second done.
REQ-031 Back-to-back: start held high continuously with fixed a=0x03, b=0x05 -> done pulses every 9 cycles, each with diff=0xFE, bout=1; busy low only during done cycles.
REQ-032 Reset mid-operation: rst_n low for 1 cycle at RUN cycle 4 -> all outputs 0 at once, no done pulse; next start with a=0x20, b=0x10 gives diff=0x10, bout=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. One bit of (a - b) is produced per clock,
// LSB first, through a single full-subtractor cell and a borrow flop. A start
// accepted at edge N produces a one-cycle done pulse during the cycle that
// follows edge N+WIDTH. diff and bout are registered and hold their value
// until the next completed operation (or reset).
//
// Ports
//   clk    : clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   start  : request to begin a subtraction (accepted in IDLE or DONE)
//   a      : minuend, captured on the accepting edge
//   b      : subtrahend, captured on the accepting edge
//   busy   : high while the state is RUN
//   done   : high for the single cycle the state is DONE
//   diff   : registered (a - b) mod 2^WIDTH
//   bout   : registered borrow-out, 1 when a < b (unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Wide enough to hold WIDTH itself, so the count never wraps mid-operation.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             br;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  // Full-subtractor cell on the current operand LSBs.
  always_comb begin
    ai      = a_sr[0];
    bi      = b_sr[0];
    d       = ai ^ bi ^ br;
    br_next = (~ai & bi) | (~(ai ^ bi) & br);
    // The result fills from the MSB side, so after WIDTH shifts the first
    // (LSB) bit has arrived at position 0.
    r_next  = {d, r_sr[WIDTH-1:1]};
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_next;
          br   <= br_next;
          cnt  <= cnt + CNT_ONE;
          // Last bit: publish the result on the same edge that enters DONE.
          if (cnt == LAST_BIT) begin
            diff  <= r_next;
            bout  <= br_next;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive start for exactly one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #23;
    tests++;
    if ({busy, done, diff, bout} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b diff=%02h bout=%0b want all 0",
               busy, done, diff, bout);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int n;
    int busy_cnt;
    start_op(8'h5A, 8'h3C);
    busy_cnt = 0;
    n = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (diff !== 8'h00) begin
        tests++;
        fails++;
        $display("FAIL basic_diff_hold: got diff=%02h want 00 during RUN", diff);
      end
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL basic_latency: got %0d edges want 8", n);
    end
    tests++;
    if (busy_cnt !== 8) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h1E || bout !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: got done=%0b busy=%0b diff=%02h bout=%0b want 1 0 1e 0",
               done, busy, diff, bout);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h1E || bout !== 1'b0) begin
      fails++;
      $display("FAIL basic_after: got done=%0b busy=%0b diff=%02h bout=%0b want 0 0 1e 0",
               done, busy, diff, bout);
    end
  endtask

  task automatic test_boundaries();
    int n;
    start_op(8'h00, 8'h01);
    wait_done(n);
    tests++;
    if (n !== 8 || diff !== 8'hFF || bout !== 1'b1) begin
      fails++;
      $display("FAIL underflow: got n=%0d diff=%02h bout=%0b want 8 ff 1", n, diff, bout);
    end
    @(posedge clk);
    #1;
    start_op(8'hFF, 8'hFF);
    wait_done(n);
    tests++;
    if (n !== 8 || diff !== 8'h00 || bout !== 1'b0) begin
      fails++;
      $display("FAIL equal: got n=%0d diff=%02h bout=%0b want 8 00 0", n, diff, bout);
    end
    @(posedge clk);
    #1;
    start_op(8'h00, 8'hFF);
    wait_done(n);
    tests++;
    if (n !== 8 || diff !== 8'h01 || bout !== 1'b1) begin
      fails++;
      $display("FAIL zero_minus_max: got n=%0d diff=%02h bout=%0b want 8 01 1", n, diff, bout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_while_busy();
    int n;
    int extra;
    start_op(8'h80, 8'h01);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start_op(8'h10, 8'h01);
    a = 8'hAA;
    b = 8'h55;
    wait_done(n);
    tests++;
    if (n !== 5 || diff !== 8'h7F || bout !== 1'b0) begin
      fails++;
      $display("FAIL busy_start: got n=%0d diff=%02h bout=%0b want 5 7f 0", n, diff, bout);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL busy_start_second_done: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int busy_bad;
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h05;
    @(posedge clk);
    #1;
    wait_done(n);
    tests++;
    if (n !== 8 || diff !== 8'hFE || bout !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: got n=%0d diff=%02h bout=%0b want 8 fe 1", n, diff, bout);
    end
    for (int k = 0; k < 3; k++) begin
      busy_bad = 0;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
        if (!done && !busy) busy_bad++;
      end while (!done && n < 40);
      tests++;
      if (n !== 9 || diff !== 8'hFE || bout !== 1'b1 || busy !== 1'b0 || busy_bad !== 0) begin
        fails++;
        $display("FAIL b2b_period%0d: got n=%0d diff=%02h bout=%0b busy=%0b gaps=%0d want 9 fe 1 0 0",
                 k, n, diff, bout, busy, busy_bad);
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    int extra;
    start_op(8'h55, 8'h11);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, diff, bout} !== '0) begin
      fails++;
      $display("FAIL reset_mid_immediate: got busy=%0b done=%0b diff=%02h bout=%0b want all 0",
               busy, done, diff, bout);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy || diff !== 8'h00 || bout) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got %0d bad cycles want 0", extra);
    end
    start_op(8'h20, 8'h10);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_restart_accept: got busy=%0b want 1", busy);
    end
    wait_done(n);
    tests++;
    if (n !== 8 || diff !== 8'h10 || bout !== 1'b0) begin
      fails++;
      $display("FAIL reset_restart: got n=%0d diff=%02h bout=%0b want 8 10 0", n, diff, bout);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
